// File: rtl/rect_pkg.sv
// Shared definitions for the rectangle pipeline: default geometry, writer
// state encoding and the linear framebuffer address function.
package rect_pkg;

  localparam int DEF_WIDTH   = 640;
  localparam int DEF_HEIGHT  = 480;
  localparam int DEF_COLOR_W = 8;
  localparam int DEF_ADDR_W  = 19;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } wr_state_e;

  // Full 64-bit product so callers decide how to truncate.
  function automatic logic [63:0] lin_addr(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input int unsigned width);
    return ({32'd0, y} * 64'(width)) + {32'd0, x};
  endfunction

endpackage

// File: rtl/rect_clip_addr.sv
// Combinational screen clip test and linear address for one pixel coordinate.
module rect_clip_addr
  import rect_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [31:0]       x_i,
  input  logic [31:0]       y_i,
  output logic              clip_o,
  output logic [ADDR_W-1:0] addr_o
);

  // Unsigned compare: negative coordinates wrap to huge values and clip.
  assign clip_o = (x_i >= 32'(WIDTH)) || (y_i >= 32'(HEIGHT));
  assign addr_o = ADDR_W'(lin_addr(x_i, y_i, WIDTH));

endmodule

// File: rtl/rect_pixel_writer.sv
// Accepts plotted pixels, drops off-screen ones and issues stallable single
// word framebuffer writes, pulsing frame_done when a rectangle's last pixel retires.
module rect_pixel_writer
  import rect_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_x,
  input  logic [31:0]        in_y,
  input  logic               in_last,
  input  logic [COLOR_W-1:0] in_color,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ready,
  output logic               frame_done,
  output logic [31:0]        pix_written,
  output logic [31:0]        pix_clipped,
  output wr_state_e          dbg_state
);

  // Handshake: a pixel transfers on a rising edge where in_valid && in_ready;
  // a write retires on a rising edge where mem_we && mem_ready. in_ready
  // depends only on state and mem_ready, never on in_valid.

  wr_state_e          state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [COLOR_W-1:0] data_q;
  logic               last_q;
  logic               done_q;
  logic [31:0]        written_q;
  logic [31:0]        clipped_q;

  logic              clip;
  logic [ADDR_W-1:0] addr_d;
  logic              xfer, on_xfer, off_xfer, wr_done;

  rect_clip_addr #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_clip_addr (
    .x_i   (in_x),
    .y_i   (in_y),
    .clip_o(clip),
    .addr_o(addr_d)
  );

  assign in_ready = (state_q == IDLE) || mem_ready;
  assign xfer     = in_valid && in_ready;
  assign on_xfer  = xfer && !clip;
  assign off_xfer = xfer && clip;
  assign wr_done  = (state_q == PEND) && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      written_q <= '0;
      clipped_q <= '0;
    end else begin
      // A new on-screen pixel replaces a retiring write with no bubble.
      if (on_xfer) begin
        state_q <= PEND;
        addr_q  <= addr_d;
        data_q  <= in_color;
        last_q  <= in_last;
      end else if (wr_done) begin
        state_q <= IDLE;
      end
      if (wr_done && (written_q != 32'hFFFF_FFFF)) written_q <= written_q + 32'd1;
      if (off_xfer && (clipped_q != 32'hFFFF_FFFF)) clipped_q <= clipped_q + 32'd1;
      done_q <= (wr_done && last_q) || (off_xfer && in_last);
    end
  end

  assign mem_we      = (state_q == PEND);
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign frame_done  = done_q;
  assign pix_written = written_q;
  assign pix_clipped = clipped_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rect_pixel_writer.sv
// Directed bench for rect_pixel_writer: single pixel, stalled stream, clipping,
// back-to-back burst, corner address, coincident last pixels and mid-write reset.
module tb_rect_pixel_writer;
  import rect_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y;
  logic        in_last;
  logic [7:0]  in_color;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        frame_done;
  logic [31:0] pix_written, pix_clipped;
  wr_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  rect_pixel_writer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last), .in_color(in_color),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .frame_done(frame_done), .pix_written(pix_written), .pix_clipped(pix_clipped),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [31:0] x, input logic [31:0] y,
                    input logic [7:0] c, input logic l);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_color = c;
    in_last  = l;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0; in_color = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_written", pix_written, 0);
    chk("rst_clipped", pix_clipped, 0);
    chk("rst_state", dbg_state, IDLE);

    // Single pixel (3,2) -> address 2*640+3
    mem_ready = 1'b1;
    px(3, 2, 8'h5A, 1'b1);
    tick(); idle_in();
    chk("p1_we", mem_we, 1);
    chk("p1_addr", mem_addr, 1283);
    chk("p1_data", mem_data, 8'h5A);
    chk("p1_state", dbg_state, PEND);
    chk("p1_done_early", frame_done, 0);
    tick();
    chk("p1_we_off", mem_we, 0);
    chk("p1_done", frame_done, 1);
    chk("p1_written", pix_written, 1);

    // Four pixels along y=0, the second one stalls for three cycles
    px(0, 0, 8'h10, 1'b0);
    tick();
    chk("s_done_clear", frame_done, 0);
    chk("s0_addr", mem_addr, 0);
    chk("s0_data", mem_data, 8'h10);
    px(1, 0, 8'h11, 1'b0);
    tick();
    chk("s1_addr", mem_addr, 1);
    chk("s1_written", pix_written, 2);
    mem_ready = 1'b0;
    px(2, 0, 8'h12, 1'b0);
    #1;
    chk("s_stall_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_stall_we", mem_we, 1);
      chk("s_stall_addr", mem_addr, 1);
      chk("s_stall_data", mem_data, 8'h11);
      chk("s_stall_written", pix_written, 2);
      chk("s_stall_ready2", in_ready, 0);
    end
    mem_ready = 1'b1;
    #1;
    chk("s_release_ready", in_ready, 1);
    tick();
    chk("s2_addr", mem_addr, 2);
    chk("s2_data", mem_data, 8'h12);
    chk("s2_written", pix_written, 3);
    px(3, 0, 8'h13, 1'b0);
    tick(); idle_in();
    chk("s3_addr", mem_addr, 3);
    chk("s3_written", pix_written, 4);
    tick();
    chk("s_end_we", mem_we, 0);
    chk("s_end_written", pix_written, 5);
    chk("s_end_done", frame_done, 0);

    // Off-screen pixels, last flag on the third
    px(640, 0, 8'h01, 1'b0);
    tick();
    chk("c1_we", mem_we, 0);
    chk("c1_clipped", pix_clipped, 1);
    px(0, 480, 8'h02, 1'b0);
    tick();
    chk("c2_we", mem_we, 0);
    chk("c2_clipped", pix_clipped, 2);
    chk("c2_done", frame_done, 0);
    px(32'hFFFF_FFFF, 5, 8'h03, 1'b1);
    tick(); idle_in();
    chk("c3_we", mem_we, 0);
    chk("c3_clipped", pix_clipped, 3);
    chk("c3_done", frame_done, 1);
    chk("c3_written", pix_written, 5);
    tick();
    chk("c3_done_off", frame_done, 0);

    // 100 back-to-back on-screen pixels along y=7
    for (int i = 0; i < 100; i++) begin
      px(i, 7, 8'(i), 1'b0);
      #1;
      chk("b_ready", in_ready, 1);
      tick();
      chk("b_we", mem_we, 1);
      chk("b_addr", mem_addr, 4480 + i);
    end
    idle_in();
    tick();
    chk("b_end_we", mem_we, 0);
    chk("b_written", pix_written, 105);

    // Bottom-right corner pixel, held by a stall
    mem_ready = 1'b0;
    px(639, 479, 8'hC3, 1'b0);
    tick(); idle_in();
    chk("corner_addr", mem_addr, 307199);
    chk("corner_data", mem_data, 8'hC3);
    tick();
    chk("corner_hold", mem_addr, 307199);
    chk("corner_hold_we", mem_we, 1);
    mem_ready = 1'b1;
    tick();
    chk("corner_written", pix_written, 106);
    chk("corner_we_off", mem_we, 0);

    // Written-last and clipped-last retire on the same edge: one pulse
    mem_ready = 1'b0;
    px(1, 1, 8'h77, 1'b1);
    tick();
    chk("dual_pend", mem_we, 1);
    mem_ready = 1'b1;
    px(700, 0, 8'h78, 1'b1);
    tick(); idle_in();
    chk("dual_done", frame_done, 1);
    chk("dual_written", pix_written, 107);
    chk("dual_clipped", pix_clipped, 4);
    chk("dual_we", mem_we, 0);
    tick();
    chk("dual_done_off", frame_done, 0);

    // Reset while a last-flagged write is pending
    mem_ready = 1'b0;
    px(10, 10, 8'h99, 1'b1);
    tick(); idle_in();
    chk("r_pend_addr", mem_addr, 6410);
    chk("r_pend_we", mem_we, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    chk("r_we", mem_we, 0);
    chk("r_written", pix_written, 0);
    chk("r_clipped", pix_clipped, 0);
    chk("r_state", dbg_state, IDLE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_no_done", frame_done, 0);
      chk("r_no_we", mem_we, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_pixel_writer.md
# rect_pixel_writer

Downstream consumer of the rectangle plot state machine. Accepts the stream of plotted (x, y) pixel coordinates over a valid/ready handshake, discards off-screen pixels, converts on-screen pixels to linear framebuffer addresses, and issues single-word writes to framebuffer memory that can stall. Pulses a completion flag once the last pixel of a rectangle has retired.

## Interface
- WIDTH, 640: screen width in pixels
- HEIGHT, 480: screen height in pixels
- COLOR_W, 8: pixel colour width
- ADDR_W, 19: framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  pixel present on in_x/in_y
- in_ready  out  1  writer accepts pixel this cycle
- in_x  in  32  pixel x, unsigned
- in_y  in  32  pixel y, unsigned
- in_last  in  1  final pixel of current rectangle
- in_color  in  COLOR_W  colour, sampled with the pixel
- mem_we  out  1  write request pending
- mem_addr  out  ADDR_W  y*WIDTH + x
- mem_data  out  COLOR_W  colour to write
- mem_ready  in  1  memory takes the write this cycle
- frame_done  out  1  one-cycle pulse: last pixel retired
- pix_written  out  32  count of pixels written
- pix_clipped  out  32  count of pixels discarded

## Operation
- States: IDLE (no write pending, mem_we=0) and PEND (mem_we=1, holding mem_addr/mem_data stable until mem_ready).
- in_ready = (state==IDLE) || mem_ready. Transfer occurs on an edge with in_valid && in_ready.
- Clip: pixel is off-screen if in_x >= WIDTH or in_y >= HEIGHT (unsigned compare; negative values from upstream wrap and are clipped).
- On-screen transfer: register addr = in_y*WIDTH + in_x (computed at full width, truncated to ADDR_W), data = in_color, last flag; go/stay PEND.
- Off-screen transfer: pixel dropped; pix_clipped increments; state goes IDLE if the pending write also completed this edge, else unchanged.
- PEND with mem_ready and no new on-screen transfer: -> IDLE, pix_written increments.
- PEND with mem_ready and simultaneous on-screen transfer: stays PEND with new addr/data (back-to-back, no bubble).
- frame_done: high for exactly one cycle after the edge on which a last-flagged pixel retires (written: its mem_ready edge; clipped: its acceptance edge). If both a written-last and a clipped-last retire on the same edge, frame_done is a single pulse.
- Counters saturate at 2^32-1.
- Outputs with in_valid low: no state change except pending-write completion.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_data=0, frame_done=0, pix_written=0, pix_clipped=0, state IDLE.
- Reset mid-write: pending write abandoned, not counted; mem_we low the cycle after the reset edge.
- Latency: pixel accepted at edge N -> mem_we=1 with its address from cycle N+1.
- Throughput: one pixel per cycle while mem_ready is held high.
- mem_addr/mem_data/mem_we stable while mem_we=1 and mem_ready=0.
- in_ready is combinational from state and mem_ready; no combinational path from in_valid to any output.

## Structure
- Shared package rect_pkg: default WIDTH/HEIGHT/COLOR_W, writer state enum (IDLE, PEND), and the address function lin_addr(x, y) used by both this block and future readback logic.
- One sub-module, rect_clip_addr: combinational clip flag and linear address from (x, y); instantiated once at the input.

## Test plan
- Single pixel (3,2), color 0x5A, mem_ready=1, in_last=1 -> mem_we one cycle with mem_addr=1283, mem_data=0x5A; frame_done pulses next cycle; pix_written=1.
- Stream 4 pixels (0..3,0) with mem_ready low for 3 cycles on the second -> in_ready low during stall, addresses 0,1,2,3 in order, addr/data held stable, pix_written=4.
- Pixels (640,0), (0,480), (0xFFFFFFFF,5) with last on the third -> no mem_we, pix_clipped=3, frame_done pulses once after third acceptance.
- Back-to-back 100 on-screen pixels with mem_ready=1 -> 100 consecutive mem_we cycles, no bubbles, in_ready continuously 1.
- Reset asserted while PEND at (10,10) -> mem_we=0 next cycle, counters 0, frame_done never fires for that pixel.
- Corner pixel (639,479), ADDR_W=19 -> mem_addr=307199.
